regfile_write_arbiter: RTL and testbench

// - Shares the 4 write ports of the 128-entry multi-port register file among NUM_REQ write requesters.
// - Arbitration is round-robin; each cycle grants up to NUM_WPORTS writes to distinct addresses.
// - Granted writes are registered and driven onto the W*_en/addr/data ports one cycle later.
// - Sits between the execution/writeback units and the register file, on the register-file clock.

---
 rtl/regfile_arb_pkg.sv | 26 ++
 rtl/regfile_wr_alloc.sv | 60 ++++++
 rtl/regfile_write_arbiter.sv | 99 +++++++++
 tb/tb_regfile_write_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_arb_pkg.sv
// Shared widths, write-request types and ring-index helpers for the register-file write arbiter.
package regfile_arb_pkg;

  localparam int ADDR_W     = 7;
  localparam int DATA_W     = 9;
  localparam int NUM_WPORTS = 4;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

  typedef struct packed {
    addr_t addr;
    data_t data;
  } wr_req_t;

  // Next index around a ring of n requesters.
  function automatic int ring_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

  // Scan position of requester 'to' when the scan starts at 'from'.
  function automatic int ring_dist(input int from, input int to, input int n);
    return (to >= from) ? to - from : to - from + n;
  endfunction

endpackage

// File: rtl/regfile_wr_alloc.sv
// Combinational round-robin allocation of write ports to requesters, rejecting duplicate addresses.
// Zero latency; a requester is denied when ports run out or its address is already granted this cycle.
module regfile_wr_alloc #(
  parameter int NUM_REQ    = 6,
  parameter int NUM_WPORTS = regfile_arb_pkg::NUM_WPORTS,
  parameter int ADDR_W     = regfile_arb_pkg::ADDR_W,
  parameter int PTR_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [PTR_W-1:0]            rr_ptr_i,
  input  logic [NUM_REQ-1:0]          valid_i,
  input  logic [NUM_REQ*ADDR_W-1:0]   addr_i,
  output logic [NUM_REQ-1:0]          grant_o,
  output logic [NUM_WPORTS*PTR_W-1:0] port_idx_o,
  output logic [NUM_WPORTS-1:0]       port_used_o,
  output logic                        conflict_o
);
  import regfile_arb_pkg::*;

  logic [ADDR_W-1:0]     taken [NUM_WPORTS];
  logic [NUM_WPORTS-1:0] used;
  logic                  hit;
  int                    n_grant;

  always_comb begin
    grant_o    = '0;
    port_idx_o = '0;
    conflict_o = 1'b0;
    used       = '0;
    hit        = 1'b0;
    n_grant    = 0;
    for (int k = 0; k < NUM_WPORTS; k++) taken[k] = '0;

    // Outer loop is scan order; inner loop picks the requester at that position
    for (int s = 0; s < NUM_REQ; s++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (ring_dist(int'(rr_ptr_i), i, NUM_REQ) == s && valid_i[i] && n_grant < NUM_WPORTS) begin
          hit = 1'b0;
          for (int k = 0; k < NUM_WPORTS; k++) begin
            if (used[k] && taken[k] == addr_i[i*ADDR_W +: ADDR_W]) hit = 1'b1;
          end
          if (hit) begin
            conflict_o = 1'b1;
          end else begin
            grant_o[i] = 1'b1;
            for (int k = 0; k < NUM_WPORTS; k++) begin
              if (k == n_grant) begin
                port_idx_o[k*PTR_W +: PTR_W] = PTR_W'(i);
                used[k]                      = 1'b1;
                taken[k]                     = addr_i[i*ADDR_W +: ADDR_W];
              end
            end
            n_grant = n_grant + 1;
          end
        end
      end
    end
    port_used_o = used;
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write ports among NUM_REQ requesters, round-robin, distinct addresses only.
// Grants are combinational (ready); granted writes reach the wr_* ports one cycle later.
module regfile_write_arbiter #(
  parameter int NUM_REQ    = 6,
  parameter int NUM_WPORTS = regfile_arb_pkg::NUM_WPORTS,
  parameter int ADDR_W     = regfile_arb_pkg::ADDR_W,
  parameter int DATA_W     = regfile_arb_pkg::DATA_W,
  parameter int CNT_W      = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]    req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [NUM_WPORTS-1:0]        wr_en,
  output logic [NUM_WPORTS*ADDR_W-1:0] wr_addr,
  output logic [NUM_WPORTS*DATA_W-1:0] wr_data,
  output logic [CNT_W-1:0]             conflict_cnt
);
  import regfile_arb_pkg::*;

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]          grant;
  logic [NUM_WPORTS*PTR_W-1:0] port_idx;
  logic [NUM_WPORTS-1:0]       port_used;
  logic                        conflict;
  logic [PTR_W-1:0]            last_idx;

  logic [PTR_W-1:0]             rr_ptr_q, rr_ptr_d;
  logic [NUM_WPORTS-1:0]        wr_en_q, wr_en_d;
  logic [NUM_WPORTS*ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [NUM_WPORTS*DATA_W-1:0] wr_data_q, wr_data_d;
  logic [CNT_W-1:0]             conflict_cnt_q, conflict_cnt_d;

  regfile_wr_alloc #(
    .NUM_REQ    (NUM_REQ),
    .NUM_WPORTS (NUM_WPORTS),
    .ADDR_W     (ADDR_W),
    .PTR_W      (PTR_W)
  ) u_alloc (
    .rr_ptr_i    (rr_ptr_q),
    .valid_i     (req_valid),
    .addr_i      (req_addr),
    .grant_o     (grant),
    .port_idx_o  (port_idx),
    .port_used_o (port_used),
    .conflict_o  (conflict)
  );

  assign req_ready = reset ? '0 : grant;

  always_comb begin
    wr_en_d   = port_used;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    last_idx  = rr_ptr_q;
    for (int k = 0; k < NUM_WPORTS; k++) begin
      if (port_used[k]) begin
        // Ports fill in scan order, so the highest used port holds the last grant
        last_idx = port_idx[k*PTR_W +: PTR_W];
        for (int i = 0; i < NUM_REQ; i++) begin
          if (port_idx[k*PTR_W +: PTR_W] == PTR_W'(i)) begin
            wr_addr_d[k*ADDR_W +: ADDR_W] = req_addr[i*ADDR_W +: ADDR_W];
            wr_data_d[k*DATA_W +: DATA_W] = req_data[i*DATA_W +: DATA_W];
          end
        end
      end
    end

    rr_ptr_d = (|port_used) ? PTR_W'(ring_next(int'(last_idx), NUM_REQ)) : rr_ptr_q;

    conflict_cnt_d = conflict_cnt_q;
    if (conflict && conflict_cnt_q != '1) conflict_cnt_d = conflict_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_ptr_q       <= '0;
      wr_en_q        <= '0;
      wr_addr_q      <= '0;
      wr_data_q      <= '0;
      conflict_cnt_q <= '0;
    end else begin
      rr_ptr_q       <= rr_ptr_d;
      wr_en_q        <= wr_en_d;
      wr_addr_q      <= wr_addr_d;
      wr_data_q      <= wr_data_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign wr_en        = wr_en_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench: stimulus queues the expected port writes, a negedge monitor checks them.
module tb_regfile_write_arbiter;
  import regfile_arb_pkg::*;

  localparam int NR = 6;
  localparam int NW = 4;
  localparam int AW = 7;
  localparam int DW = 9;
  localparam int CW = 16;

  logic              clock = 1'b0;
  logic              reset;
  logic [NR-1:0]     req_valid;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_data;
  logic [NR-1:0]     req_ready;
  logic [NW-1:0]     wr_en;
  logic [NW*AW-1:0]  wr_addr;
  logic [NW*DW-1:0]  wr_data;
  logic [CW-1:0]     conflict_cnt;

  regfile_write_arbiter #(
    .NUM_REQ    (NR),
    .NUM_WPORTS (NW),
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .CNT_W      (CW)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_addr     (req_addr),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .conflict_cnt (conflict_cnt)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [NW-1:0]      en;
    wr_req_t [NW-1:0]   w;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          mon_e;
  int            n_vec = 0;
  int            n_err = 0;
  logic [AW-1:0] ra [NR];
  logic [DW-1:0] rd [NR];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  task automatic seta(input int i, input int a);
    ra[i] = AW'(a);
    rd[i] = DW'(a * 5 + i * 64 + 1);
  endtask

  task automatic drive(input logic [NR-1:0] v);
    req_valid = v;
    for (int i = 0; i < NR; i++) begin
      req_addr[i*AW +: AW] = ra[i];
      req_data[i*DW +: DW] = rd[i];
    end
  endtask

  // Expected port contents: r<k> names the requester routed to port k (-1 = unused)
  function automatic exp_t mk(input logic [NW-1:0] en, input int r0, input int r1,
                              input int r2, input int r3);
    exp_t e;
    int   r [NW];
    r = '{r0, r1, r2, r3};
    e = '0;
    e.en = en;
    for (int k = 0; k < NW; k++) begin
      if (r[k] >= 0) begin
        e.w[k].addr = ra[r[k]];
        e.w[k].data = rd[r[k]];
      end
    end
    return e;
  endfunction

  always @(negedge clock) begin
    if (wr_en !== '0) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_write: wr_en=%b with no write outstanding", wr_en);
      end else begin
        logic dup;
        mon_e = exp_q.pop_front();
        chk("wr_en", 32'(wr_en), 32'(mon_e.en));
        for (int k = 0; k < NW; k++) begin
          if (mon_e.en[k]) begin
            chk($sformatf("wr_addr[%0d]", k), 32'(wr_addr[k*AW +: AW]), 32'(mon_e.w[k].addr));
            chk($sformatf("wr_data[%0d]", k), 32'(wr_data[k*DW +: DW]), 32'(mon_e.w[k].data));
          end
        end
        dup = 1'b0;
        for (int k = 0; k < NW; k++)
          for (int j = 0; j < k; j++)
            if (wr_en[k] && wr_en[j] && wr_addr[k*AW +: AW] == wr_addr[j*AW +: AW]) dup = 1'b1;
        chk("addr_unique", 32'(dup), 32'(0));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with every requester asking
    reset = 1'b1;
    for (int i = 0; i < NR; i++) seta(i, i);
    drive(6'b111111);
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_ready", 32'(req_ready), 32'(0));
    chk("rst_wr_en", 32'(wr_en), 32'(0));
    chk("rst_cnt", 32'(conflict_cnt), 32'(0));
    reset = 1'b0;
    drive(6'b000000);
    #1 chk("idle_ready", 32'(req_ready), 32'(0));

    // Six requesters, four ports, then the two leftovers
    @(negedge clock);
    drive(6'b111111);
    #1 chk("t2_ready_a", 32'(req_ready), 32'(6'b001111));
    exp_q.push_back(mk(4'b1111, 0, 1, 2, 3));
    @(negedge clock);
    drive(6'b110000);
    #1 chk("t2_ready_b", 32'(req_ready), 32'(6'b110000));
    exp_q.push_back(mk(4'b0011, 4, 5, -1, -1));
    @(negedge clock);
    drive(6'b000000);
    #1 chk("t2_idle_ready", 32'(req_ready), 32'(0));
    @(negedge clock);
    chk("t2_idle_wr_en", 32'(wr_en), 32'(0));
    chk("t2_cnt", 32'(conflict_cnt), 32'(0));

    // Same-address conflict between req1 and req2
    seta(1, 7);
    seta(2, 7);
    drive(6'b000110);
    #1 chk("t3_ready_a", 32'(req_ready), 32'(6'b000010));
    chk("t3_cnt_before", 32'(conflict_cnt), 32'(0));
    exp_q.push_back(mk(4'b0001, 1, -1, -1, -1));
    @(negedge clock);
    chk("t3_cnt_after", 32'(conflict_cnt), 32'(1));
    drive(6'b000100);
    #1 chk("t3_ready_b", 32'(req_ready), 32'(6'b000100));
    exp_q.push_back(mk(4'b0001, 2, -1, -1, -1));
    @(negedge clock);
    chk("t3_cnt_hold", 32'(conflict_cnt), 32'(1));

    // Move pointer to 5, then check wrap-around port ordering
    seta(4, 20);
    drive(6'b010000);
    #1 chk("t4_ready_a", 32'(req_ready), 32'(6'b010000));
    exp_q.push_back(mk(4'b0001, 4, -1, -1, -1));
    @(negedge clock);
    seta(5, 9);
    seta(0, 3);
    drive(6'b100001);
    #1 chk("t4_ready_b", 32'(req_ready), 32'(6'b100001));
    exp_q.push_back(mk(4'b0011, 5, 0, -1, -1));

    // Port exhaustion denies req0 whose address duplicates req1: not a conflict
    @(negedge clock);
    seta(1, 10); seta(2, 11); seta(3, 12); seta(4, 13); seta(5, 14); seta(0, 10);
    drive(6'b111111);
    #1 chk("exh_ready_a", 32'(req_ready), 32'(6'b011110));
    exp_q.push_back(mk(4'b1111, 1, 2, 3, 4));
    @(negedge clock);
    chk("exh_no_conflict", 32'(conflict_cnt), 32'(1));
    drive(6'b100001);
    #1 chk("exh_ready_b", 32'(req_ready), 32'(6'b100001));
    exp_q.push_back(mk(4'b0011, 5, 0, -1, -1));

    // Reset between edges while all four ports are enabled
    @(negedge clock);
    for (int i = 0; i < NR; i++) seta(i, 30 + i);
    drive(6'b111111);
    #1 chk("t5_ready", 32'(req_ready), 32'(6'b011110));
    exp_q.push_back(mk(4'b1111, 1, 2, 3, 4));
    @(negedge clock);
    drive(6'b000000);
    #2 reset = 1'b1;
    drive(6'b111111);
    #1 chk("t5_wr_en_dropped", 32'(wr_en), 32'(0));
    chk("t5_cnt_cleared", 32'(conflict_cnt), 32'(0));
    chk("t5_ready_in_reset", 32'(req_ready), 32'(0));
    @(negedge clock);
    reset = 1'b0;
    seta(0, 40);
    seta(5, 41);
    drive(6'b100001);
    #1 chk("t5_ready_after", 32'(req_ready), 32'(6'b100001));
    exp_q.push_back(mk(4'b0011, 0, 5, -1, -1));
    @(negedge clock);
    drive(6'b000000);
    @(negedge clock);
    chk("t5_idle_wr_en", 32'(wr_en), 32'(0));

    // Conflict every cycle until the counter saturates
    seta(0, 5);
    seta(1, 5);
    drive(6'b000011);
    for (int c = 0; c < (1 << CW) + 4; c++) begin
      #1;
      if (c == 0) chk("sat_ready0", 32'(req_ready), 32'(6'b000001));
      if (c == 1) chk("sat_ready1", 32'(req_ready), 32'(6'b000010));
      exp_q.push_back(mk(4'b0001, c % 2, -1, -1, -1));
      @(negedge clock);
      if (c == 0) chk("sat_cnt_1", 32'(conflict_cnt), 32'(1));
      if (c + 1 == (1 << CW) - 2) chk("sat_cnt_fffe", 32'(conflict_cnt), 32'(16'hFFFE));
      if (c + 1 == (1 << CW) - 1) chk("sat_cnt_ffff", 32'(conflict_cnt), 32'(16'hFFFF));
    end
    chk("sat_cnt_hold", 32'(conflict_cnt), 32'(16'hFFFF));
    drive(6'b000000);
    @(negedge clock);
    @(negedge clock);
    chk("final_wr_en", 32'(wr_en), 32'(0));
    chk("scoreboard_empty", 32'(exp_q.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
